pdl_meas: RTL and testbench

Pulse delay/width measurement unit: the receive-side counterpart of the pulse delay generator. It watches an external trigger and a returned pulse, and measures two intervals in `clk` cycles (10 ns at 100 MHz): trigger rising edge to pulse rising edge, and pulse high time. Results are presented in the same `dl`/`wb` units the generator consumes, which makes generator loopback checking and external timing characterisation possible.

---
 rtl/pdl_meas.sv | 156 +++++++++++++++
 tb/tb_pdl_meas.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pdl_meas.sv
// pdl_meas: pulse delay/width measurement unit.
// Measures, in clk cycles, trigger-rise to pulse-rise delay and pulse high time.
// Both async inputs go through identical 2-FF synchronisers, so the sync
// latency cancels out of both measurements.
module pdl_meas #(
  parameter int unsigned N       = 32,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         enable,
  input  logic         trigger,
  input  logic         pulse_in,
  output logic [N-1:0] dl_meas,
  output logic [N-1:0] wb_meas,
  output logic         meas_valid,
  output logic         timeout_err,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    WIDTH = 2'd2
  } state_e;

  localparam logic [N-1:0] CNT_ONE = N'(1);
  localparam logic [N-1:0] CNT_MAX = '1;
  localparam logic [N-1:0] TO_VAL  = N'(TIMEOUT);
  localparam bit           TO_EN   = (TIMEOUT != 0);

  state_e       state_q, state_d;
  logic         trig_s1_q, trig_s2_q;
  logic         pulse_s1_q, pulse_s2_q;
  logic [N-1:0] dcnt_q, dcnt_d;
  logic [N-1:0] wcnt_q, wcnt_d;
  logic [N-1:0] dl_reg_q, dl_reg_d;
  logic [N-1:0] dl_meas_q, dl_meas_d;
  logic [N-1:0] wb_meas_q, wb_meas_d;
  logic         meas_valid_q, meas_valid_d;
  logic         timeout_err_q, timeout_err_d;
  logic         busy_q, busy_d;

  logic trig_rise;
  logic pulse_rise;
  logic pulse_fall;

  // Two-stage synchronisers for the asynchronous trigger and pulse inputs.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trig_s1_q  <= 1'b0;
      trig_s2_q  <= 1'b0;
      pulse_s1_q <= 1'b0;
      pulse_s2_q <= 1'b0;
    end else begin
      trig_s1_q  <= trigger;
      trig_s2_q  <= trig_s1_q;
      pulse_s1_q <= pulse_in;
      pulse_s2_q <= pulse_s1_q;
    end
  end

  assign trig_rise  = trig_s1_q & ~trig_s2_q;
  assign pulse_rise = pulse_s1_q & ~pulse_s2_q;
  assign pulse_fall = pulse_s2_q & ~pulse_s1_q;

  // Next-state logic: phase sequencing, saturating counters, result capture.
  // NOTE: every signal gets its hold/default value first so no path through
  // the case leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    dcnt_d        = dcnt_q;
    wcnt_d        = wcnt_q;
    dl_reg_d      = dl_reg_q;
    dl_meas_d     = dl_meas_q;
    wb_meas_d     = wb_meas_q;
    meas_valid_d  = 1'b0;
    timeout_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A pulse rise coinciding with the accepted trigger is not looked at.
        if (enable && trig_rise) begin
          state_d = DELAY;
          dcnt_d  = CNT_ONE;
        end
      end
      DELAY: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (pulse_rise) begin
          dl_reg_d = dcnt_q;
          wcnt_d   = CNT_ONE;
          state_d  = WIDTH;
        end else if (TO_EN && (dcnt_q == TO_VAL)) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else if (dcnt_q != CNT_MAX) begin
          dcnt_d = dcnt_q + CNT_ONE;
        end
      end
      WIDTH: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (pulse_fall) begin
          dl_meas_d    = dl_reg_q;
          wb_meas_d    = wcnt_q;
          meas_valid_d = 1'b1;
          state_d      = IDLE;
        end else if (TO_EN && (wcnt_q == TO_VAL)) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else if (wcnt_q != CNT_MAX) begin
          wcnt_d = wcnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, counter and registered-output update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      dcnt_q        <= '0;
      wcnt_q        <= '0;
      dl_reg_q      <= '0;
      dl_meas_q     <= '0;
      wb_meas_q     <= '0;
      meas_valid_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      dcnt_q        <= dcnt_d;
      wcnt_q        <= wcnt_d;
      dl_reg_q      <= dl_reg_d;
      dl_meas_q     <= dl_meas_d;
      wb_meas_q     <= wb_meas_d;
      meas_valid_q  <= meas_valid_d;
      timeout_err_q <= timeout_err_d;
      busy_q        <= busy_d;
    end
  end

  assign dl_meas     = dl_meas_q;
  assign wb_meas     = wb_meas_q;
  assign meas_valid  = meas_valid_q;
  assign timeout_err = timeout_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_pdl_meas.sv
// Testbench for pdl_meas: two instances (N=8, TIMEOUT=0 and TIMEOUT=50) share
// stimulus; expected results come from interval arithmetic on the waveform.
module tb_pdl_meas;

  localparam int NB   = 8;
  localparam int NONE = -1;
  localparam int INF  = 1 << 30;
  localparam int SAT  = (1 << NB) - 1;

  logic clk = 1'b0;
  logic reset_n;
  logic enable;
  logic trigger;
  logic pulse_in;

  logic [NB-1:0] dl_o   [2];
  logic [NB-1:0] wb_o   [2];
  logic          mv_o   [2];
  logic          to_o   [2];
  logic          busy_o [2];

  int n_checks = 0;
  int n_fail   = 0;
  int exp_dl [2];
  int exp_wb [2];
  int to_val [2] = '{0, 50};

  always #5 clk = ~clk;

  pdl_meas #(.N(NB), .TIMEOUT(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable), .trigger(trigger),
    .pulse_in(pulse_in), .dl_meas(dl_o[0]), .wb_meas(wb_o[0]),
    .meas_valid(mv_o[0]), .timeout_err(to_o[0]), .busy(busy_o[0])
  );

  pdl_meas #(.N(NB), .TIMEOUT(50)) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(enable), .trigger(trigger),
    .pulse_in(pulse_in), .dl_meas(dl_o[1]), .wb_meas(wb_o[1]),
    .meas_valid(mv_o[1]), .timeout_err(to_o[1]), .busy(busy_o[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_results(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s.dl%0d", tag, d), 32'(dl_o[d]), 32'(exp_dl[d]));
      check($sformatf("%s.wb%0d", tag, d), 32'(wb_o[d]), 32'(exp_wb[d]));
    end
  endtask

  // Sample index at which the measurement ends (strobe seen), or INF if the
  // window of l samples closes first. Pulse rise k cycles after trigger gives
  // delay k; a rise at k<1 coincides with the trigger and is not seen.
  function automatic int end_sample(input int k, input int w, input int t,
                                    input int l, output bit valid);
    int e;
    e     = INF;
    valid = 1'b0;
    if (k < 1 || (t != 0 && k > t)) begin
      if (t != 0) e = t + 1;
    end else if (w == NONE || (t != 0 && w > t)) begin
      if (t != 0) e = k + t + 1;
    end else begin
      e     = k + w + 1;
      valid = 1'b1;
    end
    if (e > l - 1) begin
      e     = INF;
      valid = 1'b0;
    end
    return e;
  endfunction

  // Trigger at cycle 0 (3 cycles high), optional second trigger at t2,
  // pulse high from cycle k for w cycles (NONE = never rises / never falls).
  // After l cycles enable is dropped to abort anything still running.
  task automatic run(input string tag, input int k, input int w, input int l, input int t2);
    int  e [2];
    bit  valid [2];
    int  nv [2], nt [2], nb [2], both [2], first_v [2], first_t [2];
    int  ab_busy, ab_strobe;
    for (int d = 0; d < 2; d++) begin
      e[d] = end_sample(k, w, to_val[d], l, valid[d]);
      nv[d] = 0; nt[d] = 0; nb[d] = 0; both[d] = 0;
      first_v[d] = NONE; first_t[d] = NONE;
    end
    for (int c = 0; c < l; c++) begin
      @(negedge clk);
      trigger  = (c < 3) || (t2 >= 0 && c >= t2 && c < t2 + 2);
      pulse_in = (k != NONE) && (c >= k) && (w == NONE || c < k + w);
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        if (mv_o[d]) begin nv[d]++; if (first_v[d] == NONE) first_v[d] = c; end
        if (to_o[d]) begin nt[d]++; if (first_t[d] == NONE) first_t[d] = c; end
        if (busy_o[d]) nb[d]++;
        if (mv_o[d] && to_o[d]) both[d]++;
      end
    end
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s.nvalid%0d", tag, d), 32'(nv[d]), valid[d] ? 32'd1 : 32'd0);
      check($sformatf("%s.ntimeout%0d", tag, d), 32'(nt[d]),
            (!valid[d] && e[d] != INF) ? 32'd1 : 32'd0);
      check($sformatf("%s.busycyc%0d", tag, d), 32'(nb[d]),
            (e[d] == INF) ? 32'(l - 1) : 32'(e[d] - 1));
      check($sformatf("%s.both%0d", tag, d), 32'(both[d]), 32'd0);
      if (e[d] != INF)
        check($sformatf("%s.endat%0d", tag, d),
              valid[d] ? 32'(first_v[d]) : 32'(first_t[d]), 32'(e[d]));
      if (valid[d]) begin
        exp_dl[d] = (k > SAT) ? SAT : k;
        exp_wb[d] = (w > SAT) ? SAT : w;
      end
    end
    check_results(tag);
    // Abort phase: busy must be low from the first edge after enable drops.
    ab_busy = 0; ab_strobe = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      enable = 1'b0; trigger = 1'b0; pulse_in = 1'b0;
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        if (busy_o[d]) ab_busy++;
        if (mv_o[d] || to_o[d]) ab_strobe++;
      end
    end
    check({tag, ".abort_busy"}, 32'(ab_busy), 32'd0);
    check({tag, ".abort_strobe"}, 32'(ab_strobe), 32'd0);
    check_results({tag, ".abort"});
    @(negedge clk);
    enable = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int k, w, seen;
    reset_n  = 1'b0;
    enable   = 1'b0;
    trigger  = 1'b0;
    pulse_in = 1'b0;
    exp_dl   = '{0, 0};
    exp_wb   = '{0, 0};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst.busy%0d", d), 32'(busy_o[d]), 32'd0);
      check($sformatf("rst.mv%0d", d), 32'(mv_o[d]), 32'd0);
      check($sformatf("rst.to%0d", d), 32'(to_o[d]), 32'd0);
    end
    check_results("rst");
    @(negedge clk);
    reset_n = 1'b1;
    enable  = 1'b1;
    repeat (3) @(negedge clk);

    // Basic: delay 25, width 40.
    run("basic", 25, 40, 72, NONE);
    // No pulse at all: timeout in delay phase (TIMEOUT=50 instance only).
    run("no_pulse", NONE, NONE, 60, NONE);
    // Pulse stuck high: timeout in width phase.
    run("stuck_hi", 10, NONE, 70, NONE);
    // Saturating delay.
    run("saturate", 300, 3, 310, NONE);
    // Edge wins over timeout in the same cycle; one beyond times out.
    run("edge_eq_to", 50, 50, 106, NONE);
    run("delay_gt_to", 51, 5, 62, NONE);
    // Minimum delay and width.
    run("min", 1, 1, 8, NONE);
    // Pulse rising together with the trigger is ignored.
    run("coincident", 0, 5, 60, NONE);
    // Second trigger during WIDTH is ignored.
    run("retrig", 10, 5, 22, 12);

    // A pulse with no new trigger must not start a measurement.
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      pulse_in = (c >= 1 && c < 4);
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++)
        if (mv_o[d] || to_o[d] || busy_o[d]) seen++;
    end
    check("no_trig.activity", 32'(seen), 32'd0);
    check_results("no_trig");

    // enable dropped mid-WIDTH.
    run("abort_width", 10, NONE, 20, NONE);

    // Asynchronous reset mid-DELAY.
    @(negedge clk);
    trigger = 1'b1;
    repeat (3) @(negedge clk);
    trigger = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++)
      check($sformatf("mid_delay.busy%0d", d), 32'(busy_o[d]), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    exp_dl = '{0, 0};
    exp_wb = '{0, 0};
    for (int d = 0; d < 2; d++) begin
      check($sformatf("async_rst.busy%0d", d), 32'(busy_o[d]), 32'd0);
      check($sformatf("async_rst.mv%0d", d), 32'(mv_o[d]), 32'd0);
      check($sformatf("async_rst.to%0d", d), 32'(to_o[d]), 32'd0);
    end
    check_results("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Random delay/width pairs, as a loopback generator would produce.
    for (int i = 0; i < 100; i++) begin
      k = int'($urandom_range(60, 1));
      w = int'($urandom_range(60, 1));
      run($sformatf("rnd%0d", i), k, w, k + w + 6, NONE);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
